regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (reg_write/write_reg/write_data) between two writeback
//  sources: the ALU and the multi-cycle load unit. Each source gets a one-entry buffer with a valid/ready
//  handshake. Grants go oldest-first, and the winner drives a registered write port.
//  Also flags decode-stage RAW hazards on writes that are still buffered (not yet on the port).
// PARAMETERS
//  DATA_W        32  width of write data
//  ADDR_W        5   register index width (32 registers, x0 hard-wired zero)
//  TIE_MEM_FIRST 1   when both slots were filled in the same cycle: 1 = grant MEM first, 0 = ALU first
// PORTS
//  clk         in   1       single clock, all state on posedge
//  rst         in   1       synchronous, active-high reset
//  alu_valid   in   1       ALU writeback request
//  alu_ready   out  1       ALU request accepted when alu_valid && alu_ready
//  alu_rd      in   ADDR_W  ALU destination register
//  alu_data    in   DATA_W  ALU result
//  mem_valid   in   1       load writeback request
//  mem_ready   out  1       load request accepted when mem_valid && mem_ready
//  mem_rd      in   ADDR_W  load destination register
//  mem_data    in   DATA_W  load result
//  reg_write   out  1       write enable to register file (registered)
//  write_reg   out  ADDR_W  write index (registered)
//  write_data  out  DATA_W  write data (registered)
//  chk_reg1    in   ADDR_W  decode source register 1
//  chk_reg2    in   ADDR_W  decode source register 2
//  hazard1     out  1       chk_reg1 matches a buffered, not-yet-issued write
//  hazard2     out  1       chk_reg2 matches a buffered, not-yet-issued write
// BEHAVIOUR
//  - Reset (rst=1 at posedge): both slots empty, age state cleared, reg_write=0, write_reg=0, write_data=0.
//    rst mid-operation discards buffered entries. No write is issued in the cycle after reset.
//  - Slot per source holds {rd,data}, plus a full flag and a fill-order tag.
//    Slot states: EMPTY -> FULL on accept; FULL -> EMPTY on grant; FULL -> FULL on grant + same-cycle accept.
//  - xx_ready = !xx_full || xx_grant (combinational from slot state only; no valid->ready path).
//  - Accept with rd==0: handshake completes, entry dropped, slot stays EMPTY, no port write ever.
//  - Arbitration (combinational, each cycle): grant exactly one FULL slot.
//    If only one slot is full, it wins. If both are full, the older fill wins.
//    If both were filled in the same cycle, TIE_MEM_FIRST decides.
//    Oldest-first preserves program order for same-rd writes.
//  - Port: at posedge, reg_write <= any_grant; write_reg/write_data <= granted slot.
//    With no grant, reg_write <= 0 and write_reg/write_data hold their values.
//  - Latency: accept in cycle N -> slot FULL in N+1 -> granted in N+1 at the earliest
//    -> reg_write=1 during N+2 -> register file updated at the end of N+2.
//  - Throughput: 1 write per cycle sustained. A source whose slot is granted can accept a new entry
//    in the same cycle (back-to-back).
//  - Hazards: hazardN = (chk_regN != 0) && any FULL slot has rd == chk_regN.
//    The output stage is excluded, because the register file bypasses write_data for a same-cycle read.
//    A slot being granted this cycle still counts as a hazard.
//  - The arbiter performs no arithmetic. Widths pass through unchanged.
// STRUCTURE
//  - Shared package regfile_pkg: ADDR_W, DATA_W, ZERO_REG=5'd0, source encoding SRC_ALU=0/SRC_MEM=1.
//  - Sub-module wb_slot (one-entry buffer: full flag, rd, data, fill tag, ready logic), instantiated twice.
//  - Top level holds the age comparison, the grant mux, the output register and the hazard compares.
// TESTING
//  1. Reset: pulse rst with both slots full -> next cycle reg_write=0, alu_ready=mem_ready=1,
//     hazard1=hazard2=0.
//  2. Single ALU write: alu_valid, rd=5, data=0xDEADBEEF in cycle 0 -> reg_write=1, write_reg=5,
//     write_data=0xDEADBEEF in cycle 2. hazard1=1 in cycle 1 with chk_reg1=5.
//  3. Simultaneous fill, TIE_MEM_FIRST=1: ALU rd=3/0x11 and MEM rd=3/0x22 in cycle 0
//     -> port shows 0x22 in cycle 2, then 0x11 in cycle 3.
//  4. Age order: MEM rd=7 accepted in cycle 0 while the ALU slot is stalled, then ALU rd=7 in cycle 1
//     -> MEM's write reaches the port before ALU's.
//  5. x0 discard: alu_valid with rd=0 -> alu_ready=1, reg_write never asserted, hazard1=0 for chk_reg1=0.
//  6. Back-to-back: ALU valid on 4 consecutive cycles, rd=1..4, MEM idle -> alu_ready stays 1,
//     4 consecutive port writes in cycles 2..5.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and encodings for the register-file writeback arbiter.
// Fill tags are short wrapping stamps; a slot never waits more than a couple of cycles.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer: holds {rd,data} plus the stamp of the cycle it was filled.
// Writes to x0 complete the handshake but are never stored.
module wb_slot #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int TAG_W  = regfile_pkg::TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    input  logic [TAG_W-1:0]  stamp,
    output logic              full,
    output logic [ADDR_W-1:0] slot_rd,
    output logic [DATA_W-1:0] slot_data,
    output logic [TAG_W-1:0]  tag
);

    logic accept;
    logic rd_nonzero;

    // Ready depends only on slot state so there is no valid->ready path.
    assign ready      = !full || grant;
    assign accept     = valid && ready;
    assign rd_nonzero = (rd != ADDR_W'(regfile_pkg::ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            slot_rd   <= '0;
            slot_data <= '0;
            tag       <= '0;
        end else if (accept && rd_nonzero) begin
            full      <= 1'b1;
            slot_rd   <= rd;
            slot_data <= data;
            tag       <= stamp;
        end else if (grant) begin
            full      <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback, oldest fill first,
// and flags decode RAW hazards against writes still sitting in the buffers.
module regfile_wb_arbiter #(
    parameter int DATA_W        = regfile_pkg::DATA_W,
    parameter int ADDR_W        = regfile_pkg::ADDR_W,
    parameter bit TIE_MEM_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              hazard1,
    output logic              hazard2
);

    localparam int TAG_W = regfile_pkg::TAG_W;

    logic [TAG_W-1:0]  stamp;
    logic              alu_full, mem_full;
    logic [ADDR_W-1:0] alu_slot_rd, mem_slot_rd;
    logic [DATA_W-1:0] alu_slot_data, mem_slot_data;
    logic [TAG_W-1:0]  alu_tag, mem_tag;
    logic [TAG_W-1:0]  alu_age, mem_age;
    logic              alu_grant, mem_grant, any_grant;
    regfile_pkg::src_e grant_src;

    always_ff @(posedge clk) begin
        if (rst) stamp <= '0;
        else     stamp <= stamp + 1'b1;
    end

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) u_alu_slot (
        .clk(clk), .rst(rst), .valid(alu_valid), .ready(alu_ready),
        .rd(alu_rd), .data(alu_data), .grant(alu_grant), .stamp(stamp),
        .full(alu_full), .slot_rd(alu_slot_rd), .slot_data(alu_slot_data), .tag(alu_tag)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) u_mem_slot (
        .clk(clk), .rst(rst), .valid(mem_valid), .ready(mem_ready),
        .rd(mem_rd), .data(mem_data), .grant(mem_grant), .stamp(stamp),
        .full(mem_full), .slot_rd(mem_slot_rd), .slot_data(mem_slot_data), .tag(mem_tag)
    );

    // Age in cycles since fill; modular difference is safe because waits are short.
    assign alu_age = stamp - alu_tag;
    assign mem_age = stamp - mem_tag;

    always_comb begin
        grant_src = regfile_pkg::SRC_ALU;
        if (alu_full && mem_full) begin
            if ((mem_age > alu_age) || ((mem_age == alu_age) && TIE_MEM_FIRST))
                grant_src = regfile_pkg::SRC_MEM;
        end else if (mem_full) begin
            grant_src = regfile_pkg::SRC_MEM;
        end
        any_grant = alu_full || mem_full;
        alu_grant = any_grant && (grant_src == regfile_pkg::SRC_ALU);
        mem_grant = any_grant && (grant_src == regfile_pkg::SRC_MEM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            reg_write <= any_grant;
            if (mem_grant) begin
                write_reg  <= mem_slot_rd;
                write_data <= mem_slot_data;
            end else if (alu_grant) begin
                write_reg  <= alu_slot_rd;
                write_data <= alu_slot_data;
            end
        end
    end

    // The output stage is bypassed by the register file, so only buffered entries are hazards.
    assign hazard1 = (chk_reg1 != ADDR_W'(regfile_pkg::ZERO_REG)) &&
                     ((alu_full && (alu_slot_rd == chk_reg1)) || (mem_full && (mem_slot_rd == chk_reg1)));
    assign hazard2 = (chk_reg2 != ADDR_W'(regfile_pkg::ZERO_REG)) &&
                     ((alu_full && (alu_slot_rd == chk_reg2)) || (mem_full && (mem_slot_rd == chk_reg2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: entry-level reference model plus directed literal checks.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam bit TIE = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_rd, mem_rd, chk_reg1, chk_reg2;
    logic [DW-1:0] alu_data, mem_data;
    logic          reg_write, hazard1, hazard2;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIE_MEM_FIRST(TIE)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending entries with absolute fill cycles, and the expected port contents.
    int            cyc = 0;
    bit            m_init = 0;
    bit            a_full, m_full;
    logic [AW-1:0] a_rd, m_rd;
    logic [DW-1:0] a_dat, m_dat;
    int            a_fill, m_fill;
    bit            p_we;
    logic [AW-1:0] p_reg;
    logic [DW-1:0] p_dat;

    function automatic bit pending(input logic [AW-1:0] r);
        return (r != 0) && ((a_full && a_rd == r) || (m_full && m_rd == r));
    endfunction

    always @(negedge clk) begin
        bit ag, mg, ar, mr;
        ag = a_full && (!m_full || (a_fill < m_fill) || (a_fill == m_fill && !TIE));
        mg = m_full && !ag;
        ar = !a_full || ag;
        mr = !m_full || mg;
        if (m_init) begin
            check("alu_ready", alu_ready, ar);
            check("mem_ready", mem_ready, mr);
            check("hazard1", hazard1, pending(chk_reg1));
            check("hazard2", hazard2, pending(chk_reg2));
            check("reg_write", reg_write, p_we);
            check("write_reg", write_reg, p_reg);
            check("write_data", write_data, p_dat);
        end
        if (rst) begin
            m_init = 1;
            a_full = 0; m_full = 0;
            p_we = 0; p_reg = '0; p_dat = '0;
        end else if (m_init) begin
            p_we = ag || mg;
            if (mg)      begin p_reg = m_rd; p_dat = m_dat; end
            else if (ag) begin p_reg = a_rd; p_dat = a_dat; end
            if (ag) a_full = 0;
            if (mg) m_full = 0;
            if (alu_valid && ar && alu_rd != 0) begin
                a_full = 1; a_rd = alu_rd; a_dat = alu_data; a_fill = cyc;
            end
            if (mem_valid && mr && mem_rd != 0) begin
                m_full = 1; m_rd = mem_rd; m_dat = mem_data; m_fill = cyc;
            end
        end
        cyc++;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        alu_valid = 0; mem_valid = 0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
        chk_reg1 = '0; chk_reg2 = '0;
        for (int i = 0; i < n; i++) go();
    endtask

    task automatic drive_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
        alu_valid = 1; alu_rd = r; alu_data = d;
    endtask

    task automatic drive_mem(input logic [AW-1:0] r, input logic [DW-1:0] d);
        mem_valid = 1; mem_rd = r; mem_data = d;
    endtask

    initial begin
        rst = 1;
        idle(0);
        go(); go();
        rst = 0;
        idle(2);

        // Single ALU write
        drive_alu(5'd5, 32'hDEADBEEF); sample(); go();
        idle(0); chk_reg1 = 5'd5; sample();
        check("t2_hazard1", hazard1, 1'b1);
        go(); chk_reg1 = 0; sample();
        check("t2_we", reg_write, 1'b1);
        check("t2_reg", write_reg, 5'd5);
        check("t2_data", write_data, 32'hDEADBEEF);
        idle(3);

        // Simultaneous fill, MEM wins the tie
        drive_alu(5'd3, 32'h11); drive_mem(5'd3, 32'h22); sample(); go();
        idle(0); sample(); go(); sample();
        check("t3_first", write_data, 32'h22);
        go(); sample();
        check("t3_second", write_data, 32'h11);
        check("t3_we", reg_write, 1'b1);
        idle(3);

        // Older MEM fill drains before younger ALU fill
        drive_mem(5'd7, 32'hA7); sample(); go();
        idle(0); drive_alu(5'd7, 32'hB7); sample(); go();
        idle(0); sample();
        check("t4_first", write_data, 32'hA7);
        go(); sample();
        check("t4_second", write_data, 32'hB7);
        idle(3);

        // x0 discard
        drive_alu(5'd0, 32'h55); chk_reg1 = 5'd0; sample();
        check("t5_ready", alu_ready, 1'b1);
        check("t5_hazard1", hazard1, 1'b0);
        go(); idle(0);
        for (int i = 0; i < 3; i++) begin
            sample(); check("t5_no_write", reg_write, 1'b0); go();
        end
        idle(2);

        // Back-to-back ALU writes
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive_alu(AW'(k + 1), DW'(32'h100 + k + 1));
            else idle(0);
            sample();
            if (k < 4) check("t6_ready", alu_ready, 1'b1);
            if (k >= 2) begin
                check("t6_we", reg_write, 1'b1);
                check("t6_reg", write_reg, AW'(k - 1));
                check("t6_data", write_data, DW'(32'h100 + k - 1));
            end
            go();
        end
        idle(3);

        // Reset with both slots full
        drive_alu(5'd9, 32'h1); drive_mem(5'd10, 32'h2); go();
        idle(0); rst = 1; go();
        rst = 0; chk_reg1 = 5'd9; chk_reg2 = 5'd10; sample();
        check("t1_we", reg_write, 1'b0);
        check("t1_alu_ready", alu_ready, 1'b1);
        check("t1_mem_ready", mem_ready, 1'b1);
        check("t1_hazard1", hazard1, 1'b0);
        check("t1_hazard2", hazard2, 1'b0);
        go();

        // Random traffic, small register range to force collisions
        for (int i = 0; i < 3000; i++) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            mem_valid = ($urandom_range(0, 9) < 5);
            alu_rd    = AW'($urandom_range(0, 7));
            mem_rd    = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_data  = $urandom;
            chk_reg1  = AW'($urandom_range(0, 7));
            chk_reg2  = AW'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 199) == 0);
            go();
        end
        rst = 0;
        idle(3);
        sample();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
